// File: rtl/eth_h2e_pkt_gate.sv
// Store-and-forward gate between host DMA and eth_internal h2e_*: frames are buffered whole
// and only complete, well-formed frames are released downstream.
module eth_h2e_pkt_gate #(
    parameter int ADDR_W        = 9,
    parameter int MAX_PKT_WORDS = 1200,
    parameter int MIN_PKT_WORDS = 2
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [63:0]       s_axis_tdata,
    input  logic [7:0]        s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [63:0]       m_axis_tdata,
    output logic [7:0]        m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [31:0]       stat_pkt_cnt,
    output logic [15:0]       stat_drop_cnt,
    output logic              stat_drop_pulse,
    output logic [ADDR_W:0]   fifo_words,
    output logic [1:0]        dbg_ingress_state
);

    // Handshake: a beat moves on either stream only in a cycle where valid and ready are both 1;
    // valid never waits on ready, and payload is held stable while valid & !ready.

    localparam int CNT_W = $clog2(MAX_PKT_WORDS + 2);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PKT_WORDS);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PKT_WORDS);
    localparam logic [CNT_W-1:0] SAT_C = CNT_W'(MAX_PKT_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BODY = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_p1;
    logic [ADDR_W-1:0] wr_commit_q, commit_val_q, commit_val_d, commit_base;
    logic              commit_pend_q, commit_pend_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d, beat_cnt_inc;
    logic              ready_q, beat, full, keep_ok;
    logic              wr_en, drop_evt, pkt_inc;

    logic [72:0]       mem [DEPTH];
    logic [ADDR_W-1:0] fetch_ptr_q, rd_ptr_q;
    logic              rd_v_q, rd_go, pop;
    logic [72:0]       rd_q, e0_q, e1_q;
    logic [1:0]        skid_cnt_q, skid_nxt;

    assign s_axis_tready     = ready_q;
    assign beat              = s_axis_tvalid & ready_q;
    assign wr_ptr_p1         = wr_ptr_q + ADDR_W'(1);
    assign full              = (wr_ptr_p1 == rd_ptr_q);
    assign keep_ok           = (s_axis_tkeep != 8'h00) &&
                               ((s_axis_tkeep & (s_axis_tkeep + 8'h01)) == 8'h00);
    assign beat_cnt_inc      = (beat_cnt_q == SAT_C) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);
    // A commit issued last cycle is not yet in wr_commit_q; rewinds must land after it.
    assign commit_base       = commit_pend_q ? commit_val_q : wr_commit_q;
    assign fifo_words        = {1'b0, wr_ptr_q - rd_ptr_q};
    assign dbg_ingress_state = state_q;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        commit_pend_d = 1'b0;
        commit_val_d  = commit_val_q;
        wr_en         = 1'b0;
        drop_evt      = 1'b0;
        pkt_inc       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    if (s_axis_tlast) begin
                        if ((MIN_C <= CNT_W'(1)) && keep_ok && !full) begin
                            wr_en         = 1'b1;
                            wr_ptr_d      = wr_ptr_p1;
                            commit_pend_d = 1'b1;
                            commit_val_d  = wr_ptr_p1;
                            pkt_inc       = 1'b1;
                        end else begin
                            drop_evt = 1'b1;
                        end
                    end else if (full) begin
                        state_d = S_DROP;
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_d   = wr_ptr_p1;
                        beat_cnt_d = CNT_W'(1);
                        state_d    = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (beat) begin
                    if (full || (beat_cnt_inc > MAX_C)) begin
                        // An overflowing tlast beat closes the frame here rather than in DROP.
                        if (s_axis_tlast) begin
                            wr_ptr_d   = commit_base;
                            drop_evt   = 1'b1;
                            beat_cnt_d = '0;
                            state_d    = S_IDLE;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_d   = wr_ptr_p1;
                        beat_cnt_d = beat_cnt_inc;
                        if (s_axis_tlast) begin
                            beat_cnt_d = '0;
                            state_d    = S_IDLE;
                            if ((beat_cnt_inc >= MIN_C) && keep_ok) begin
                                commit_pend_d = 1'b1;
                                commit_val_d  = wr_ptr_p1;
                                pkt_inc       = 1'b1;
                            end else begin
                                wr_ptr_d = commit_base;
                                drop_evt = 1'b1;
                            end
                        end
                    end
                end
            end
            S_DROP: begin
                if (beat && s_axis_tlast) begin
                    wr_ptr_d   = commit_base;
                    drop_evt   = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            wr_commit_q     <= '0;
            commit_val_q    <= '0;
            commit_pend_q   <= 1'b0;
            beat_cnt_q      <= '0;
            ready_q         <= 1'b0;
            stat_pkt_cnt    <= '0;
            stat_drop_cnt   <= '0;
            stat_drop_pulse <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            commit_val_q    <= commit_val_d;
            commit_pend_q   <= commit_pend_d;
            beat_cnt_q      <= beat_cnt_d;
            ready_q         <= 1'b1;
            stat_drop_pulse <= drop_evt;
            if (commit_pend_q) wr_commit_q <= commit_val_q;
            if (pkt_inc) stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
            if (drop_evt && (stat_drop_cnt != 16'hFFFF)) stat_drop_cnt <= stat_drop_cnt + 16'd1;
        end
    end

    // Egress: fetch_ptr runs ahead into the read stage and skid; rd_ptr frees a slot only on pop.
    assign pop      = (skid_cnt_q != 2'd0) && m_axis_tready;
    assign skid_nxt = skid_cnt_q + {1'b0, rd_v_q} - {1'b0, pop};
    assign rd_go    = (fetch_ptr_q != wr_commit_q) && (skid_nxt < 2'd2);

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr_q] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (rd_go) rd_q <= mem[fetch_ptr_q];
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            fetch_ptr_q <= '0;
            rd_ptr_q    <= '0;
            rd_v_q      <= 1'b0;
            skid_cnt_q  <= '0;
            e0_q        <= '0;
            e1_q        <= '0;
        end else begin
            rd_v_q     <= rd_go;
            skid_cnt_q <= skid_nxt;
            if (rd_go) fetch_ptr_q <= fetch_ptr_q + ADDR_W'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            case ({rd_v_q, pop})
                2'b10: begin
                    if (skid_cnt_q == 2'd0) e0_q <= rd_q;
                    else e1_q <= rd_q;
                end
                2'b01: e0_q <= e1_q;
                2'b11: begin
                    if (skid_cnt_q == 2'd1) begin
                        e0_q <= rd_q;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tvalid = (skid_cnt_q != 2'd0);
    assign m_axis_tdata  = e0_q[63:0];
    assign m_axis_tkeep  = e0_q[71:64];
    assign m_axis_tlast  = e0_q[72];

endmodule

// File: tb/tb_eth_h2e_pkt_gate.sv
// Directed bench for eth_h2e_pkt_gate: a default-size instance and a 16-word instance
// for the overflow and counter-saturation cases.
module tb_eth_h2e_pkt_gate;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // default instance
    logic        aresetn;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast, s_tvalid, s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast, m_tvalid, m_tready;
    logic [31:0] stat_pkt_cnt;
    logic [15:0] stat_drop_cnt;
    logic        stat_drop_pulse;
    logic [9:0]  fifo_words;
    logic [1:0]  dbg_state;

    // small instance
    logic        aresetn_sm;
    logic [63:0] s_tdata_sm;
    logic [7:0]  s_tkeep_sm;
    logic        s_tlast_sm, s_tvalid_sm, s_tready_sm;
    logic [63:0] m_tdata_sm;
    logic [7:0]  m_tkeep_sm;
    logic        m_tlast_sm, m_tvalid_sm, m_tready_sm;
    logic [31:0] stat_pkt_cnt_sm;
    logic [15:0] stat_drop_cnt_sm;
    logic        stat_drop_pulse_sm;
    logic [4:0]  fifo_words_sm;
    logic [1:0]  dbg_state_sm;

    eth_h2e_pkt_gate dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .stat_pkt_cnt(stat_pkt_cnt), .stat_drop_cnt(stat_drop_cnt),
        .stat_drop_pulse(stat_drop_pulse), .fifo_words(fifo_words),
        .dbg_ingress_state(dbg_state)
    );

    eth_h2e_pkt_gate #(.ADDR_W(4)) dut_sm (
        .aclk(aclk), .aresetn(aresetn_sm),
        .s_axis_tdata(s_tdata_sm), .s_axis_tkeep(s_tkeep_sm), .s_axis_tlast(s_tlast_sm),
        .s_axis_tvalid(s_tvalid_sm), .s_axis_tready(s_tready_sm),
        .m_axis_tdata(m_tdata_sm), .m_axis_tkeep(m_tkeep_sm), .m_axis_tlast(m_tlast_sm),
        .m_axis_tvalid(m_tvalid_sm), .m_axis_tready(m_tready_sm),
        .stat_pkt_cnt(stat_pkt_cnt_sm), .stat_drop_cnt(stat_drop_cnt_sm),
        .stat_drop_pulse(stat_drop_pulse_sm), .fifo_words(fifo_words_sm),
        .dbg_ingress_state(dbg_state_sm)
    );

    logic [72:0] exp_q[$];
    logic [72:0] exp_q_sm[$];
    int n_cmp = 0;
    int n_err = 0;
    int exp_pkt = 0;
    int exp_drop = 0;
    int exp_pulse = 0;
    int pulse_cnt = 0;
    int pulse_cnt_sm = 0;
    int last_cyc = 0;
    logic rand_done = 1'b0;

    task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // scoreboards
    always @(negedge aclk) begin
        if (aresetn && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) check("sb_empty", 73'(exp_q.size()), 73'd1);
            else check("beat", {m_tlast, m_tkeep, m_tdata}, exp_q.pop_front());
        end
        if (aresetn_sm && m_tvalid_sm && m_tready_sm) begin
            if (exp_q_sm.size() == 0) check("sb_sm_empty", 73'(exp_q_sm.size()), 73'd1);
            else check("beat_sm", {m_tlast_sm, m_tkeep_sm, m_tdata_sm}, exp_q_sm.pop_front());
        end
        if (aresetn && stat_drop_pulse) pulse_cnt++;
        if (aresetn_sm && stat_drop_pulse_sm) pulse_cnt_sm++;
    end

    task automatic send_frame(input int len, input logic [7:0] last_keep, input logic good);
        for (int i = 0; i < len; i++) begin
            s_tdata  = {$urandom, $urandom};
            s_tkeep  = (i == len - 1) ? last_keep : 8'($urandom);
            s_tlast  = (i == len - 1);
            s_tvalid = 1'b1;
            if (good) exp_q.push_back({s_tlast, s_tkeep, s_tdata});
            @(posedge aclk); #1;
        end
        last_cyc = cyc;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (good) exp_pkt++;
        else begin
            exp_drop++;
            exp_pulse++;
        end
    endtask

    task automatic send_frame_sm(input int len, input logic good);
        for (int i = 0; i < len; i++) begin
            s_tdata_sm  = {$urandom, $urandom};
            s_tkeep_sm  = 8'hFF;
            s_tlast_sm  = (i == len - 1);
            s_tvalid_sm = 1'b1;
            if (good) exp_q_sm.push_back({s_tlast_sm, s_tkeep_sm, s_tdata_sm});
            @(posedge aclk); #1;
        end
        s_tvalid_sm = 1'b0;
        s_tlast_sm  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || exp_q_sm.size() != 0) && k < 20000) begin
            @(posedge aclk); #1;
            k++;
        end
        check(tag, 73'(exp_q.size() + exp_q_sm.size()), 73'd0);
        repeat (3) begin @(posedge aclk); #1; end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: time limit reached, got %0d of %0d queued beats outstanding",
                 exp_q.size(), exp_q_sm.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        s_tdata = '0; s_tkeep = '0; s_tlast = 0; s_tvalid = 0; m_tready = 1;
        s_tdata_sm = '0; s_tkeep_sm = '0; s_tlast_sm = 0; s_tvalid_sm = 0; m_tready_sm = 0;
        aresetn = 0; aresetn_sm = 0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", 73'(m_tvalid), 73'd0);
        check("rst_tdata", 73'(m_tdata), 73'd0);
        check("rst_s_tready", 73'(s_tready), 73'd0);
        check("rst_fifo_words", 73'(fifo_words), 73'd0);
        check("rst_pkt_cnt", 73'(stat_pkt_cnt), 73'd0);
        check("rst_drop_cnt", 73'(stat_drop_cnt), 73'd0);
        aresetn = 1; aresetn_sm = 1;
        @(posedge aclk); #1;
        check("s_tready_up", 73'(s_tready), 73'd1);

        // 3-beat frame, latency from last accepted beat to first output beat
        send_frame(3, 8'h0F, 1'b1);
        k = 0;
        while (!m_tvalid && k < 20) begin
            @(posedge aclk); #1;
            k++;
        end
        check("t1_latency", 73'(cyc - last_cyc), 73'd3);
        wait_drain("t1_drain");
        check("t1_pkt_cnt", 73'(stat_pkt_cnt), 73'd1);

        // runt then good 4-beat frame
        send_frame(1, 8'hFF, 1'b0);
        send_frame(4, 8'hFF, 1'b1);
        wait_drain("t2_drain");
        check("t2_drop_cnt", 73'(stat_drop_cnt), 73'd1);
        check("t2_pulses", 73'(pulse_cnt), 73'd1);
        check("t2_pkt_cnt", 73'(stat_pkt_cnt), 73'd2);

        // bad tkeep rewinds, minimal good frame follows
        send_frame(3, 8'h05, 1'b0);
        check("t4_rewind", 73'(fifo_words), 73'd0);
        send_frame(2, 8'h01, 1'b1);
        wait_drain("t4_drain");
        check("t4_pkt_cnt", 73'(stat_pkt_cnt), 73'd3);
        check("t4_drop_cnt", 73'(stat_drop_cnt), 73'd2);

        // overflow on the 16-word instance with egress stalled
        send_frame_sm(8, 1'b1);
        send_frame_sm(10, 1'b0);
        repeat (4) begin @(posedge aclk); #1; end
        check("t3_fifo_words", 73'(fifo_words_sm), 73'd8);
        check("t3_drop_cnt", 73'(stat_drop_cnt_sm), 73'd1);
        check("t3_pkt_cnt", 73'(stat_pkt_cnt_sm), 73'd1);
        check("t3_tvalid_held", 73'(m_tvalid_sm), 73'd1);
        m_tready_sm = 1;
        wait_drain("t3_drain");
        check("t3_fifo_empty", 73'(fifo_words_sm), 73'd0);

        // reset in the middle of a 5-beat frame
        for (int i = 0; i < 2; i++) begin
            s_tdata = {$urandom, $urandom}; s_tkeep = 8'hFF; s_tlast = 0; s_tvalid = 1;
            @(posedge aclk); #1;
        end
        s_tvalid = 0;
        check("t5_partial_words", 73'(fifo_words), 73'd2);
        aresetn = 0;
        @(posedge aclk); #1;
        check("t5_rst_tvalid", 73'(m_tvalid), 73'd0);
        check("t5_rst_fifo", 73'(fifo_words), 73'd0);
        check("t5_rst_pkt", 73'(stat_pkt_cnt), 73'd0);
        check("t5_rst_drop", 73'(stat_drop_cnt), 73'd0);
        check("t5_rst_s_tready", 73'(s_tready), 73'd0);
        aresetn = 1;
        exp_pkt = 0; exp_drop = 0;
        @(posedge aclk); #1;
        send_frame(3, 8'h3F, 1'b1);
        wait_drain("t5_drain");
        check("t5_pkt_cnt", 73'(stat_pkt_cnt), 73'd1);
        check("t5_drop_cnt", 73'(stat_drop_cnt), 73'd0);

        // random traffic on the default instance, saturation on the small one
        fork
            begin
                for (int f = 0; f < 200; f++) begin
                    int len;
                    logic bad;
                    logic [7:0] kp;
                    len = $urandom_range(2, 40);
                    bad = ($urandom_range(0, 7) == 0);
                    kp  = 8'hFF >> $urandom_range(0, 7);
                    send_frame(len, bad ? 8'h05 : kp, !bad);
                    repeat (3 * len) begin @(posedge aclk); #1; end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge aclk); #1;
                    m_tready = 1'($urandom_range(0, 1));
                end
                m_tready = 1;
            end
            begin
                s_tkeep_sm = 8'hFF; s_tlast_sm = 1; s_tvalid_sm = 1;
                repeat (65533) begin @(posedge aclk); #1; end
                check("sat_before", 73'(stat_drop_cnt_sm), 73'h0FFFE);
                repeat (6) begin @(posedge aclk); #1; end
                s_tvalid_sm = 0; s_tlast_sm = 0;
                check("sat_after", 73'(stat_drop_cnt_sm), 73'h0FFFF);
                repeat (3) begin @(posedge aclk); #1; end
                check("sat_pulses", 73'(pulse_cnt_sm), 73'd65540);
                check("sat_pkt_cnt", 73'(stat_pkt_cnt_sm), 73'd1);
            end
        join
        wait_drain("t6_drain");
        check("t6_pkt_cnt", 73'(stat_pkt_cnt), 73'(exp_pkt));
        check("t6_drop_cnt", 73'(stat_drop_cnt), 73'(exp_drop));
        check("t6_pulses", 73'(pulse_cnt), 73'(exp_pulse));
        check("t6_fifo_empty", 73'(fifo_words), 73'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
